oc_port_array: RTL and testbench
================================

Name: oc_port_array

Overview:
Parametrised controller for NUM_PORTS motorised open/close ports. Each port is driven by one switch input. A rising edge on the switch toggles the port's travel direction. Travel takes TRAVEL_CYCLES clocks and can reverse mid-travel. A runtime airlock interlock allows at most one port out of CLOSED at a time. The block sits between the debounced switch inputs and the port actuator/status LEDs, and generalises the single-port open/close controller.

Parameters:
NUM_PORTS, 2, number of independent port channels (1..8)
TRAVEL_CYCLES, 4, clocks for a full open or full close travel (>=1)
POS_W, 4, width of per-port position counter; must hold TRAVEL_CYCLES
AUTOCLOSE_CYCLES, 16, dwell clocks in OPEN before auto-close (only with OCPORT_AUTOCLOSE_EN)
DWELL_W, 5, width of dwell counter; must hold AUTOCLOSE_CYCLES

Ports:
Clock  in  1  system clock; all state updates on posedge
Reset  in  1  synchronous, active-high reset
SwitchFlip  in  NUM_PORTS  per-port switch level, already synchronous to Clock
Interlock  in  1  1 = airlock mode (at most one port not CLOSED); 0 = ports independent
PortOpen  out  NUM_PORTS  port i fully open
PortClosed  out  NUM_PORTS  port i fully closed
PortMoving  out  NUM_PORTS  port i in OPENING or CLOSING
Rejected  out  NUM_PORTS  one-cycle pulse: port i open request denied by interlock

Behaviour:
- Per-port FSM states: CLOSED, OPENING, OPEN, CLOSING. Each port has a position counter pos (0..TRAVEL_CYCLES).
- Edge detect: prev[i] is a register. req[i] = SwitchFlip[i] & ~prev[i]. prev loads SwitchFlip every cycle, including while Reset is high, so a switch held high through reset does not generate a request.
- Reset values: state=CLOSED, pos=0, Rejected=0, PortClosed=all 1, PortOpen=0, PortMoving=0. Reset asserted mid-travel forces CLOSED on the next posedge.
- PortOpen, PortClosed and PortMoving are decoded from registered state, so they change one cycle after the deciding posedge. Rejected is registered.
- CLOSED, with req:
  - If Interlock=1 and any other port is not CLOSED: stay CLOSED, Rejected[i]=1 for one cycle.
  - If Interlock=1 and a lower-index CLOSED port also has req this cycle: lowest index wins, losers are Rejected.
  - Otherwise: go to OPENING with pos=0.
- OPENING, no req: pos<=pos+1. If pos+1==TRAVEL_CYCLES, go to OPEN. OPENING therefore lasts exactly TRAVEL_CYCLES cycles.
- OPEN: pos=TRAVEL_CYCLES. A req goes to CLOSING.
- CLOSING, no req: pos<=pos-1. If pos-1==0, go to CLOSED.
- Reversal: req in OPENING goes to CLOSING, or directly to CLOSED if pos==0. req in CLOSING goes to OPENING. pos is kept on reversal.
- Reversal to OPENING is never interlock-checked, because the port is already the non-closed one.
- req has priority over the position step in the same cycle.
- Interlock changing 1->0 or 0->1 never affects ports already out of CLOSED. It gates only new CLOSED->OPENING transitions.
- Ports are otherwise fully independent. Simultaneous events on different ports are all processed in the same cycle.

Optional Feature:
OCPORT_AUTOCLOSE_EN
- Defined: each port has a dwell counter, cleared on entry to OPEN and incremented each cycle in OPEN. When it reaches AUTOCLOSE_CYCLES with no req, the port enters CLOSING. A req in OPEN still closes immediately. The counter is reset by Reset.
- Undefined: no dwell counter. OPEN holds indefinitely until req.

Test Plan:
1. Reset 3 cycles with SwitchFlip[0] held 1 -> no request after release. PortClosed=2'b11, PortOpen=0, Rejected=0.
2. Interlock=0, TRAVEL_CYCLES=4, SwitchFlip[0] 0->1 -> PortMoving[0]=1 for 4 cycles, then PortOpen[0]=1. Second 0->1 edge -> 4 cycles CLOSING, then PortClosed[0]=1.
3. Reversal: open port 0, edge again after 2 OPENING cycles (pos=2) -> CLOSING. PortClosed[0]=1 after exactly 2 more cycles.
4. Interlock=1, port 0 OPEN, edge on port 1 -> Rejected[1]=1 for exactly one cycle. Port 1 stays CLOSED, port 0 unaffected.
5. Interlock=1, all CLOSED, edges on ports 0 and 1 in the same cycle -> port 0 OPENING, Rejected[1]=1. With Interlock=0, both enter OPENING.
6. OCPORT_AUTOCLOSE_EN, AUTOCLOSE_CYCLES=16: open port 0, no further edges -> 16 cycles OPEN, then 4 cycles CLOSING, then PortClosed[0]=1. Reset asserted mid-CLOSING -> CLOSED on the next posedge.

Source files
------------

// File: rtl/oc_port_array.sv
// oc_port_array: NUM_PORTS motorised open/close port controllers.
// Each switch rising edge toggles that port's travel direction. Travel can
// reverse mid-stroke. An optional airlock interlock allows at most one port
// out of CLOSED at a time.
// Optional feature: define OCPORT_AUTOCLOSE_EN to close a port automatically
// after it has dwelt AUTOCLOSE_CYCLES clocks in OPEN.
module oc_port_array #(
  parameter int NUM_PORTS        = 2,
  parameter int TRAVEL_CYCLES    = 4,
  parameter int POS_W            = 4,
  parameter int AUTOCLOSE_CYCLES = 16,
  parameter int DWELL_W          = 5
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [NUM_PORTS-1:0] SwitchFlip,
  input  logic                 Interlock,
  output logic [NUM_PORTS-1:0] PortOpen,
  output logic [NUM_PORTS-1:0] PortClosed,
  output logic [NUM_PORTS-1:0] PortMoving,
  output logic [NUM_PORTS-1:0] Rejected
);

  typedef enum logic [1:0] {CLOSED, OPENING, OPEN, CLOSING} state_t;

  localparam logic [POS_W-1:0] TRAVEL = POS_W'(TRAVEL_CYCLES);
  localparam logic [POS_W-1:0] ONE    = POS_W'(1);

  // Counters that cannot hold their terminal values would silently wrap.
  if ((TRAVEL_CYCLES < 1) || (TRAVEL_CYCLES >= (1 << POS_W)) ||
      (AUTOCLOSE_CYCLES < 1) || (AUTOCLOSE_CYCLES >= (1 << DWELL_W)) ||
      (NUM_PORTS < 1) || (NUM_PORTS > 8)) begin : g_bad_cfg
    $error("oc_port_array: illegal parameter combination");
  end

  state_t                 state     [NUM_PORTS];
  state_t                 state_nxt [NUM_PORTS];
  logic   [POS_W-1:0]     pos       [NUM_PORTS];
  logic   [POS_W-1:0]     pos_nxt   [NUM_PORTS];
  logic   [NUM_PORTS-1:0] prev;
  logic   [NUM_PORTS-1:0] req;
  logic   [NUM_PORTS-1:0] is_closed;
  logic   [NUM_PORTS-1:0] open_ok;
  logic   [NUM_PORTS-1:0] rej_nxt;
`ifdef OCPORT_AUTOCLOSE_EN
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(AUTOCLOSE_CYCLES - 1);
  logic   [DWELL_W-1:0]   dwell     [NUM_PORTS];
  logic   [DWELL_W-1:0]   dwell_nxt [NUM_PORTS];
`endif

  // Rising-edge requests and per-port closed flags.
  always_comb begin
    req = SwitchFlip & ~prev;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      is_closed[i] = (state[i] == CLOSED);
    end
  end

  // Airlock arbitration: a closed port may start opening only if every other
  // port is closed and no lower-index closed port is requesting this cycle.
  always_comb begin
    open_ok = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int unsigned j = 0; j < NUM_PORTS; j++) begin
        if ((j != i) && !is_closed[j]) blocked = 1'b1;
        if ((j < i) && is_closed[j] && req[j]) blocked = 1'b1;
      end
      open_ok[i] = !Interlock || !blocked;
    end
  end

  // Next-state and position logic; a request always beats the position step.
  always_comb begin
    rej_nxt = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      state_nxt[i] = state[i];
      pos_nxt[i]   = pos[i];
`ifdef OCPORT_AUTOCLOSE_EN
      dwell_nxt[i] = '0;
`endif
      unique case (state[i])
        CLOSED: begin
          pos_nxt[i] = '0;
          if (req[i]) begin
            if (open_ok[i]) state_nxt[i] = OPENING;
            else            rej_nxt[i]   = 1'b1;
          end
        end
        OPENING: begin
          if (req[i]) begin
            state_nxt[i] = (pos[i] == '0) ? CLOSED : CLOSING;
          end else if (pos[i] + ONE == TRAVEL) begin
            state_nxt[i] = OPEN;
            pos_nxt[i]   = TRAVEL;
          end else begin
            pos_nxt[i] = pos[i] + ONE;
          end
        end
        OPEN: begin
          pos_nxt[i] = TRAVEL;
          if (req[i]) begin
            state_nxt[i] = CLOSING;
          end
`ifdef OCPORT_AUTOCLOSE_EN
          else if (dwell[i] == DWELL_LAST) begin
            state_nxt[i] = CLOSING;
          end else begin
            dwell_nxt[i] = dwell[i] + DWELL_W'(1);
          end
`endif
        end
        CLOSING: begin
          if (req[i]) begin
            state_nxt[i] = OPENING;
          end else if (pos[i] == ONE) begin
            state_nxt[i] = CLOSED;
            pos_nxt[i]   = '0;
          end else begin
            pos_nxt[i] = pos[i] - ONE;
          end
        end
        default: begin
          state_nxt[i] = CLOSED;
          pos_nxt[i]   = '0;
        end
      endcase
    end
  end

  // State register; prev tracks the switch even during reset.
  always_ff @(posedge Clock) begin
    prev <= SwitchFlip;
    if (Reset) begin
      Rejected <= '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        state[i] <= CLOSED;
        pos[i]   <= '0;
`ifdef OCPORT_AUTOCLOSE_EN
        dwell[i] <= '0;
`endif
      end
    end else begin
      Rejected <= rej_nxt;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        state[i] <= state_nxt[i];
        pos[i]   <= pos_nxt[i];
`ifdef OCPORT_AUTOCLOSE_EN
        dwell[i] <= dwell_nxt[i];
`endif
      end
    end
  end

  // Status outputs decoded from registered state.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      PortOpen[i]   = (state[i] == OPEN);
      PortClosed[i] = (state[i] == CLOSED);
      PortMoving[i] = (state[i] == OPENING) || (state[i] == CLOSING);
    end
  end

endmodule

// File: tb/tb_oc_port_array.sv
// Testbench for oc_port_array (2 ports, 4-cycle travel). Directed vectors
// push hand-computed expected outputs; a monitor compares on each negedge.
module tb_oc_port_array;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] SwitchFlip = 2'b01;
  logic       Interlock = 1'b0;
  logic [1:0] PortOpen, PortClosed, PortMoving, Rejected;

  oc_port_array #(
    .NUM_PORTS(2), .TRAVEL_CYCLES(4), .POS_W(4),
    .AUTOCLOSE_CYCLES(16), .DWELL_W(5)
  ) dut (
    .Clock(Clock), .Reset(Reset), .SwitchFlip(SwitchFlip),
    .Interlock(Interlock), .PortOpen(PortOpen), .PortClosed(PortClosed),
    .PortMoving(PortMoving), .Rejected(Rejected)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [1:0] op;
    logic [1:0] cl;
    logic [1:0] mv;
    logic [1:0] rj;
  } exp_t;

  exp_t        expq [$];
  string       nameq[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Apply inputs for one clock and queue the outputs expected after that edge.
  task automatic step(input logic r, input logic il, input logic [1:0] sw,
                      input logic [1:0] op, input logic [1:0] cl,
                      input logic [1:0] mv, input logic [1:0] rj,
                      input string nm);
    exp_t e;
    Reset = r; Interlock = il; SwitchFlip = sw;
    @(posedge Clock);
    e.op = op; e.cl = cl; e.mv = mv; e.rj = rj;
    expq.push_back(e);
    nameq.push_back(nm);
    #1;
  endtask

  // Monitor: outputs are valid every cycle, so compare one queued entry per negedge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge Clock);
      if (expq.size() > 0) begin
        e  = expq.pop_front();
        nm = nameq.pop_front();
        n_vec++;
        if ({PortOpen, PortClosed, PortMoving, Rejected} !== {e.op, e.cl, e.mv, e.rj}) begin
          n_bad++;
          $display("FAIL %s: got open=%b closed=%b moving=%b rej=%b, want open=%b closed=%b moving=%b rej=%b",
                   nm, PortOpen, PortClosed, PortMoving, Rejected, e.op, e.cl, e.mv, e.rj);
        end
      end
    end
  end

  initial begin
    // Reset with switch 0 held high: no request on release.
    repeat (3) step(1, 0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, "reset");
    step(0, 0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, "held_no_req");
    step(0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, "idle");

    // Full open then full close of port 0.
    step(0, 0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, "open0_start");
    repeat (3) step(0, 0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, "open0_travel");
    step(0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, "open0_done");
    step(0, 0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, "close0_start");
    repeat (3) step(0, 0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, "close0_travel");
    step(0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, "close0_done");

    // Reversal at pos=2: two CLOSING cycles then CLOSED.
    step(0, 0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, "rev_open");
    step(0, 0, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, "rev_pos1");
    step(0, 0, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, "rev_pos2");
    step(0, 0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, "rev_closing2");
    step(0, 0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, "rev_closing1");
    step(0, 0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, "rev_closed");

    // Interlock: port 0 open, port 1 request rejected for one cycle.
    step(0, 1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, "il_idle");
    step(0, 1, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, "il_open0");
    repeat (3) step(0, 1, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, "il_open0_travel");
    step(0, 1, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, "il_open0_done");
    step(0, 1, 2'b11, 2'b01, 2'b10, 2'b00, 2'b10, "il_reject1");
    step(0, 1, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, "il_reject_pulse_end");
    step(0, 1, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, "il_hold");
    step(0, 1, 2'b11, 2'b00, 2'b10, 2'b01, 2'b00, "il_close0");
    repeat (3) step(0, 1, 2'b11, 2'b00, 2'b10, 2'b01, 2'b00, "il_close0_travel");
    step(0, 1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, "il_closed0");

    // Simultaneous requests under interlock: lowest index wins.
    step(0, 1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, "sim_idle");
    step(0, 1, 2'b11, 2'b00, 2'b10, 2'b01, 2'b10, "sim_win0");
    repeat (3) step(0, 1, 2'b11, 2'b00, 2'b10, 2'b01, 2'b00, "sim_travel");
    step(0, 1, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, "sim_open0");
    step(0, 1, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, "sim_fall0");
    step(0, 1, 2'b11, 2'b00, 2'b10, 2'b01, 2'b00, "sim_close0");
    repeat (3) step(0, 1, 2'b11, 2'b00, 2'b10, 2'b01, 2'b00, "sim_close_travel");
    step(0, 1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, "sim_closed");

    // No interlock: both open together; enabling interlock later has no effect.
    step(0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, "both_idle");
    step(0, 0, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, "both_open");
    repeat (3) step(0, 0, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, "both_travel");
    step(0, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, "both_done");
    step(0, 1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, "il_on_both_open");
    step(0, 1, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, "both_close");
    repeat (3) step(0, 1, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, "both_close_travel");
    step(0, 1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, "both_closed");

    // Reset mid-travel forces CLOSED on the next edge.
    step(0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, "rst_idle");
    step(0, 0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, "rst_open");
    step(0, 0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, "rst_travel");
    step(1, 0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, "rst_mid");
    step(0, 0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, "rst_release");

    // OPEN dwell behaviour.
    step(0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, "dw_idle");
    step(0, 0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, "dw_open");
    repeat (3) step(0, 0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, "dw_travel");
    step(0, 0, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, "dw_open_done");
`ifdef OCPORT_AUTOCLOSE_EN
    repeat (15) step(0, 0, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, "dw_dwell");
    step(0, 0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, "dw_autoclose");
    step(0, 0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, "dw_closing");
    step(1, 0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, "dw_rst_closing");
    step(0, 0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, "dw_after_rst");
`else
    repeat (20) step(0, 0, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, "dw_hold_open");
    step(0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, "dw_fall");
    step(0, 0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, "dw_close");
    repeat (3) step(0, 0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, "dw_close_travel");
    step(0, 0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, "dw_closed");
`endif

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && expq.size() > 0; k++) @(negedge Clock);
    #1;
    if (expq.size() > 0) begin
      $display("FAIL drain: got %0d pending vectors, want 0", expq.size());
      n_bad++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
